text_console_writer: RTL
========================

// Module: text_console_writer
// PURPOSE
//  Upstream feeder of the VGA text display. Takes a byte stream from the CPU/IO bus and keeps an 80x60 text VRAM up to date.
//  Handles printable chars, CR/LF/BS/FF, line wrap, full-screen scroll and clear.
//  Drives the write port and scroll-read port of the dual-port VRAM; the display reads the other port.
//  Also supplies Cursor {row[5:0],col[6:0]} and the Blink square wave to the display stage.
// PARAMETERS
//  COLS        80   characters per row; VRAM addr = row*COLS+col
//  ROWS        60   character rows
//  BLINK_BITS  24   blink counter width; Blink toggles on every counter wrap
// PORTS
//  clk          in   1   system/VGA clock
//  rst_n        in   1   asynchronous reset, active low
//  char_valid   in   1   byte offered
//  char_in      in   8   ASCII byte
//  color_in     in   3   {R,G,B} attribute, sampled with char_in
//  char_ready   out  1   accept; transfer occurs when char_valid&&char_ready
//  vram_we      out  1   VRAM write strobe
//  vram_waddr   out  13  write address
//  vram_wdata   out  11  {color[2:0],1'b0,ascii[6:0]}
//  vram_raddr   out  13  scroll read address
//  vram_rdata   in   11  read data, valid 1 cycle after vram_raddr
//  Cursor       out  13  {row[5:0],col[6:0]}
//  Blink        out  1   cursor blink phase
// BEHAVIOUR
//  Reset values: char_ready=0, vram_we=0, vram_waddr=0, vram_wdata=0, vram_raddr=0, Cursor=0, Blink=0, blink counter=0, FSM=CLEAR.
//  States:
//   CLEAR      writes space (0x020, color 000) to addr 0..ROWS*COLS-1, one per cycle; then IDLE, Cursor=0.
//   IDLE       char_ready=1; all other states char_ready=0.
//   SCROLL     pipelined copy: cycle k reads k+COLS; cycle k+1 writes addr k with vram_rdata.
//              Covers k=0..(ROWS-1)*COLS-1 (4720 writes, 4721 cycles); then CLR_ROW.
//   CLR_ROW    writes space to the last row (80 cycles); then IDLE.
//  Accept in IDLE; vram_we asserts on the following cycle (latency 1). The Cursor update lands on the same edge.
//   0x20-0x7E: write at cursor. col<79: col+1. col=79: col=0, row+1.
//   0x0D: col=0, no write.
//   0x0A: col=0, row+1, no write.
//   0x08: col>0: col-1. col=0&&row>0: row-1, col=79. At (0,0): no move. Writes a space at the new position (skipped at (0,0)).
//   0x0C: enter CLEAR; Cursor=0 on entry.
//   Other bytes: consumed, no effect.
//  Row advance from row 59: row stays 59, enter SCROLL. The char write (if any) completes first, at the old address.
//  vram_we is high only for a single-cycle write in IDLE+1, and in CLEAR/SCROLL (from cycle 2)/CLR_ROW. Low otherwise.
//  Blink: free-running counter in all states; Blink toggles when the counter wraps to 0.
//  rst_n low at any time, mid scroll/clear included: async return to reset values. Partially moved VRAM data is left as is; full clear follows.
//  Address arithmetic: 13-bit unsigned, row*80 as (row<<6)+(row<<4). No ports exceed 4799.
// STRUCTURE
//  vga_text_defs.vh holds COLS, ROWS, CHAR_SPACE=7'h20, the control codes (CR/LF/BS/FF) and the state encodings. Shared with the display stage.
//  One sub-module: blink_gen (BLINK_BITS counter + toggle flop). The FSM and address counters stay in this file.
// TESTING
//  Reset release -> exactly 4800 writes of 0x020, addr 0..4799, char_ready rises at cycle 4801, Cursor=0.
//  'A' color 3'b010 at (0,0) -> one cycle later we=1, addr 0, data 11'h241; Cursor=13'h0001.
//  81 printable chars from (0,0) -> 81st written at addr 80; Cursor={6'd1,7'd1}.
//  Cursor (59,5), send 0x0A -> 4720 copy writes, each with wdata = rdata of addr+80. Then 80 spaces at 4720..4799; Cursor={6'd59,7'd0}.
//  0x08 at (0,0) -> no write, Cursor unchanged. 0x08 at (1,0) -> space written at addr 79, Cursor={6'd0,7'd79}.
//  rst_n pulse at scroll cycle 1000 -> outputs zeroed asynchronously, full CLEAR restarts. BLINK_BITS=4: Blink toggles every 16 cycles.

Source files
------------

// File: rtl/text_console_writer_pkg.sv
// Shared constants, state encoding and byte-decode helper for the text console writer.
package text_console_writer_pkg;

  localparam int COLS         = 80;
  localparam int ROWS         = 60;
  localparam int CELLS        = COLS * ROWS;        // 4800 character cells
  localparam int SCROLL_CELLS = (ROWS - 1) * COLS;  // cells moved up by one scroll

  localparam logic [6:0]  CHAR_SPACE = 7'h20;
  localparam logic [10:0] SPACE_CELL = {3'b000, 1'b0, CHAR_SPACE};

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SCROLL  = 2'd2,
    ST_CLR_ROW = 2'd3
  } state_t;

  // Effect of one accepted byte: optional cell write plus the new cursor.
  typedef struct packed {
    logic        we;
    logic [5:0]  wrow;
    logic [6:0]  wcol;
    logic [10:0] wdata;
    logic [5:0]  row;
    logic [6:0]  col;
    logic        scroll;
    logic        clear;
  } char_action_t;

  // row*80+col using shifts only (row*64 + row*16).
  function automatic logic [12:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {6'd0, col};
  endfunction

  function automatic char_action_t decode_char(input logic [7:0] ch, input logic [2:0] color,
                                               input logic [5:0] row, input logic [6:0] col);
    char_action_t a;
    logic         advance;
    a       = '0;
    a.wrow  = row;
    a.wcol  = col;
    a.wdata = SPACE_CELL;
    a.row   = row;
    a.col   = col;
    advance = 1'b0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      a.we    = 1'b1;
      a.wdata = {color, 1'b0, ch[6:0]};
      if (col == 7'(COLS - 1)) begin
        a.col   = 7'd0;
        advance = 1'b1;
      end else begin
        a.col = col + 7'd1;
      end
    end else begin
      case (ch)
        CODE_CR: a.col = 7'd0;
        CODE_LF: begin
          a.col   = 7'd0;
          advance = 1'b1;
        end
        CODE_BS: begin
          if (col != 7'd0) begin
            a.col  = col - 7'd1;
            a.wcol = col - 7'd1;
            a.we   = 1'b1;
          end else if (row != 6'd0) begin
            a.row  = row - 6'd1;
            a.col  = 7'(COLS - 1);
            a.wrow = row - 6'd1;
            a.wcol = 7'(COLS - 1);
            a.we   = 1'b1;
          end
        end
        CODE_FF: begin
          a.clear = 1'b1;
          a.row   = 6'd0;
          a.col   = 7'd0;
        end
        default: ;
      endcase
    end
    // Advancing past the bottom row keeps the cursor there and scrolls instead.
    if (advance) begin
      if (row == 6'(ROWS - 1)) a.scroll = 1'b1;
      else                     a.row    = row + 6'd1;
    end
    return a;
  endfunction

endpackage

// File: rtl/text_console_writer_blink_gen.sv
// Free-running blink generator: the output toggles every time the counter wraps.
module text_console_writer_blink_gen #(
  parameter int BLINK_BITS = 24
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_blink
);

  logic [BLINK_BITS-1:0] r_count;
  logic                  r_blink;

  // Count every cycle; flip the phase on the all-ones -> zero wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_blink <= 1'b0;
    end else begin
      r_count <= r_count + 1'b1;
      if (&r_count) r_blink <= ~r_blink;
    end
  end

  assign o_blink = r_blink;

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream to 80x60 text VRAM writer: printable chars, CR/LF/BS/FF, wrap, scroll, clear.
module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int BLINK_BITS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_in,
  input  logic [2:0]  color_in,
  output logic        char_ready,
  output logic        vram_we,
  output logic [12:0] vram_waddr,
  output logic [10:0] vram_wdata,
  output logic [12:0] vram_raddr,
  input  logic [10:0] vram_rdata,
  output logic [12:0] Cursor,
  output logic        Blink
);

  state_t       r_state, w_state_nxt;
  logic [12:0]  r_cnt, w_cnt_nxt;
  logic [5:0]   r_row, w_row_nxt;
  logic [6:0]   r_col, w_col_nxt;
  logic         r_we, w_we_nxt;
  logic         r_copy, w_copy_nxt;
  logic [12:0]  r_waddr, w_waddr_nxt;
  logic [10:0]  r_wdata, w_wdata_nxt;
  logic [12:0]  r_raddr, w_raddr_nxt;
  logic         w_accept;
  char_action_t w_act;

  assign w_accept = char_valid && (r_state == ST_IDLE);
  assign w_act    = decode_char(char_in, color_in, r_row, r_col);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_CLEAR;
    else        r_state <= w_state_nxt;
  end

  // Next-state decision.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_CLEAR:   if (r_cnt == 13'(CELLS)) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (w_accept) begin
          if (w_act.clear)       w_state_nxt = ST_CLEAR;
          else if (w_act.scroll) w_state_nxt = ST_SCROLL;
        end
      end
      ST_SCROLL:  if (r_cnt == 13'(SCROLL_CELLS - 1)) w_state_nxt = ST_CLR_ROW;
      ST_CLR_ROW: if (r_cnt == 13'(COLS - 1)) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output next-values: VRAM strobes, scroll read pointer, step counter and cursor.
  always_comb begin
    w_we_nxt    = 1'b0;
    w_copy_nxt  = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_raddr_nxt = r_raddr;
    w_cnt_nxt   = r_cnt + 13'd1;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    unique case (r_state)
      ST_CLEAR: begin
        // Count 0..4799 writes; the extra step at 4800 is the idle-handover cycle.
        if (r_cnt != 13'(CELLS)) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_cnt;
          w_wdata_nxt = SPACE_CELL;
        end
      end
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_accept) begin
          w_we_nxt    = w_act.we;
          w_waddr_nxt = cell_addr(w_act.wrow, w_act.wcol);
          w_wdata_nxt = w_act.wdata;
          w_row_nxt   = w_act.row;
          w_col_nxt   = w_act.col;
          // Prime the first scroll read while the char write (if any) completes.
          if (w_act.scroll) w_raddr_nxt = 13'(COLS);
        end
      end
      ST_SCROLL: begin
        // Write cell k with the word read from k+COLS one cycle earlier.
        w_we_nxt    = 1'b1;
        w_copy_nxt  = 1'b1;
        w_waddr_nxt = r_cnt;
        if (r_cnt < 13'(SCROLL_CELLS - 1)) w_raddr_nxt = r_cnt + 13'(COLS + 1);
        else                               w_cnt_nxt   = '0;
      end
      ST_CLR_ROW: begin
        w_we_nxt    = 1'b1;
        w_waddr_nxt = 13'(SCROLL_CELLS) + r_cnt;
        w_wdata_nxt = SPACE_CELL;
      end
      default: ;
    endcase
  end

  // Datapath and cursor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_we    <= 1'b0;
      r_copy  <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_raddr <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_we    <= w_we_nxt;
      r_copy  <= w_copy_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_raddr <= w_raddr_nxt;
    end
  end

  text_console_writer_blink_gen #(
    .BLINK_BITS(BLINK_BITS)
  ) u_blink_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_blink(Blink)
  );

  assign char_ready = (r_state == ST_IDLE);
  assign vram_we    = r_we;
  assign vram_waddr = r_waddr;
  // Scroll copies pass the read word straight through to the write port.
  assign vram_wdata = r_copy ? vram_rdata : r_wdata;
  assign vram_raddr = r_raddr;
  assign Cursor     = {r_row, r_col};

endmodule
